switch_selector: RTL and testbench

- Stage switch selector model. It sits directly downstream of the LVDA switch selector register and consumes its 15 SSRnH drive lines.
- Latches the 8-bit channel address once its stage-select line picks up, then returns the complemented address as feedback.
- On read command, asserts one decoded channel output; on reset command, clears the relay latch.
- The top level instantiates one copy per stage (S-IC, S-II, S-IVB, IU).

---
 rtl/switch_selector_pkg.sv | 26 ++
 rtl/switch_selector_relay_timer.sv | 27 ++
 rtl/switch_selector.sv | 100 ++++++++++
 tb/tb_switch_selector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/switch_selector_pkg.sv
// switch_selector_pkg: shared state encoding and SSRH bit map for the stage switch selector
package switch_selector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICKUP,
        LATCHED,
        READ_WAIT,
        ACTIVE,
        RESETTING
    } state_t;

    localparam int SSR_W    = 15;
    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 8;
    localparam int ADDR_LSB = 0;
    localparam int SEL_BASE = 8;
    localparam int RD_BIT   = 12;
    localparam int RST_BIT  = 13;

    // States whose exit is paced by the relay timer
    function automatic logic is_timed(input state_t s);
        return s inside {PICKUP, READ_WAIT, RESETTING};
    endfunction

endpackage

// File: rtl/switch_selector_relay_timer.sv
// switch_selector_relay_timer: loadable down-counter that strobes done on its last count
module switch_selector_relay_timer
    import switch_selector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Load on state entry, then count down to zero and park there
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // A load of N yields done on the N-th clock after the load edge
    assign done = cnt == CNT_W'(1);

endmodule

// File: rtl/switch_selector.sv
// switch_selector: one stage relay selector latching an SSRH address and issuing decoded channel commands
module switch_selector
    import switch_selector_pkg::*;
#(
    parameter int unsigned STAGE      = 0,
    parameter int unsigned PICKUP_CYC = 10,
    parameter int unsigned READ_DLY   = 5,
    parameter int unsigned RESET_CYC  = 10
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic [SSR_W-1:0]  SSRH,
    output logic [ADDR_W-1:0] FB,
    output logic              CMD_VALID,
    output logic [ADDR_W-1:0] CMD_CHAN,
    output logic              BUSY,
    output logic [CNT_W-1:0]  CMD_COUNT
);

    logic [SSR_W-1:0]  ssr_q;
    logic [ADDR_W-1:0] latch;
    logic [ADDR_W-1:0] addr;
    logic              sel;
    logic              rd;
    logic              rs;
    logic              ssr_unused;
    state_t            state;
    state_t            nxt;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;

    // Register the drive lines once; every latency counts from this copy
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST)
            ssr_q <= '0;
        else
            ssr_q <= SSRH;
    end

    assign addr       = ssr_q[ADDR_LSB +: ADDR_W];
    assign sel        = ssr_q[SEL_BASE + STAGE];
    assign rd         = ssr_q[RD_BIT];
    assign rs         = ssr_q[RST_BIT];
    assign ssr_unused = ^ssr_q;

    // Next state: relay reset wins over deselect and read in every busy state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = (sel && !rs) ? PICKUP : IDLE;
            PICKUP:    nxt = rs ? RESETTING : !sel ? IDLE : tmr_done ? LATCHED : PICKUP;
            LATCHED:   nxt = rs ? RESETTING : rd ? READ_WAIT : LATCHED;
            READ_WAIT: nxt = rs ? RESETTING : !rd ? LATCHED : tmr_done ? ACTIVE : READ_WAIT;
            ACTIVE:    nxt = rs ? RESETTING : !rd ? LATCHED : ACTIVE;
            RESETTING: nxt = tmr_done ? IDLE : RESETTING;
            default:   nxt = IDLE;
        endcase
    end

    assign tmr_load = is_timed(nxt) && nxt != state;
    assign tmr_val  = nxt == PICKUP    ? CNT_W'(PICKUP_CYC) :
                      nxt == READ_WAIT ? CNT_W'(READ_DLY)   : CNT_W'(RESET_CYC);

    switch_selector_relay_timer u_timer (
        .clk      (SIM_CLK),
        .rst      (SIM_RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Relay latch, feedback and command outputs all move with the state register
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state     <= IDLE;
            latch     <= '0;
            FB        <= '1;
            CMD_VALID <= 1'b0;
            CMD_CHAN  <= '0;
            CMD_COUNT <= '0;
        end else begin
            state <= nxt;
            if (state == PICKUP && nxt == LATCHED) begin
                latch <= addr;
                FB    <= ~addr;
            end else if (state == RESETTING && nxt == IDLE) begin
                latch <= '0;
                FB    <= '1;
            end
            CMD_VALID <= nxt == ACTIVE;
            CMD_CHAN  <= nxt == ACTIVE ? latch : '0;
            if (nxt == ACTIVE && state != ACTIVE)
                CMD_COUNT <= CMD_COUNT + 1'b1;
        end
    end

    assign BUSY = state != IDLE;

endmodule

// File: tb/tb_switch_selector.sv
// tb_switch_selector: vector table, directed corner sequences and random stimulus against a timing model
module tb_switch_selector;

    logic        SIM_CLK;
    logic        SIM_RST;
    logic [14:0] SSRH;
    logic [7:0]  fb    [3];
    logic        valid [3];
    logic [7:0]  chan  [3];
    logic        busy  [3];
    logic [7:0]  cnt   [3];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    // Instance 0: stage 1 defaults; 1: stage 1 with all delays at 1; 2: stage 0 defaults
    switch_selector #(.STAGE(1)) u_main (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SSRH(SSRH), .FB(fb[0]), .CMD_VALID(valid[0]),
        .CMD_CHAN(chan[0]), .BUSY(busy[0]), .CMD_COUNT(cnt[0]));
    switch_selector #(.STAGE(1), .PICKUP_CYC(1), .READ_DLY(1), .RESET_CYC(1)) u_fast (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SSRH(SSRH), .FB(fb[1]), .CMD_VALID(valid[1]),
        .CMD_CHAN(chan[1]), .BUSY(busy[1]), .CMD_COUNT(cnt[1]));
    switch_selector #(.STAGE(0)) u_s0 (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SSRH(SSRH), .FB(fb[2]), .CMD_VALID(valid[2]),
        .CMD_CHAN(chan[2]), .BUSY(busy[2]), .CMD_COUNT(cnt[2]));

    initial SIM_CLK = 0;
    always #5 SIM_CLK = ~SIM_CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase plus clocks elapsed since entering it
    typedef struct {
        int         ph;
        int         el;
        logic [7:0] latch;
        logic [7:0] fb;
        logic [7:0] chan;
        logic       valid;
        logic [7:0] cnt;
    } mst_t;

    mst_t        m [3];
    int          sel_idx [3] = '{9, 9, 8};
    int          pu_n    [3] = '{10, 1, 10};
    int          rd_n    [3] = '{5, 1, 5};
    int          rc_n    [3] = '{10, 1, 10};
    logic [14:0] r;

    task automatic step(input int k, input logic [14:0] v);
        mst_t s;
        logic sel, rd, rs;
        s   = m[k];
        sel = v[sel_idx[k]];
        rd  = v[12];
        rs  = v[13];
        if (s.ph == 0) begin
            if (sel && !rs) begin s.ph = 1; s.el = 0; end
        end else if (rs && s.ph != 5) begin
            s.ph = 5; s.el = 0; s.valid = 0; s.chan = 0;
        end else begin
            case (s.ph)
                1: if (!sel) s.ph = 0;
                   else if (++s.el >= pu_n[k]) begin s.latch = v[7:0]; s.fb = ~v[7:0]; s.ph = 2; end
                2: if (rd) begin s.ph = 3; s.el = 0; end
                3: if (!rd) s.ph = 2;
                   else if (++s.el >= rd_n[k]) begin s.ph = 4; s.valid = 1; s.chan = s.latch; s.cnt++; end
                4: if (!rd) begin s.ph = 2; s.valid = 0; s.chan = 0; end
                5: if (++s.el >= rc_n[k]) begin s.ph = 0; s.latch = 0; s.fb = 8'hFF; end
                default: ;
            endcase
        end
        m[k] = s;
    endtask

    always @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            for (int k = 0; k < 3; k++)
                m[k] = '{ph: 0, el: 0, latch: 8'h00, fb: 8'hFF, chan: 8'h00, valid: 1'b0, cnt: 8'h00};
            r = '0;
        end else begin
            for (int k = 0; k < 3; k++) step(k, r);
            r = SSRH;
        end
    end

    always @(negedge SIM_CLK) begin
        if (mon_en)
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model%0d_fb", k),    fb[k],           m[k].fb);
                chk($sformatf("model%0d_valid", k), 8'(valid[k]),    8'(m[k].valid));
                chk($sformatf("model%0d_chan", k),  chan[k],         m[k].chan);
                chk($sformatf("model%0d_busy", k),  8'(busy[k]),     8'(m[k].ph != 0));
                chk($sformatf("model%0d_count", k), cnt[k],          m[k].cnt);
            end
    end

    typedef struct {
        logic [14:0] ssrh;
        int          cyc;
        logic [7:0]  fb;
        logic        valid;
        logic [7:0]  chan;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk_main(input string nm, input logic [7:0] f, input logic v,
                            input logic [7:0] c, input logic b, input logic [7:0] n);
        chk({nm, "_fb"},    fb[0],          f);
        chk({nm, "_valid"}, 8'(valid[0]),   8'(v));
        chk({nm, "_chan"},  chan[0],        c);
        chk({nm, "_busy"},  8'(busy[0]),    8'(b));
        chk({nm, "_count"}, cnt[0],         n);
    endtask

    initial begin
        tbl = '{
            '{15'h025A, 11, 8'hFF, 0, 8'h00, 1, 8'd0},
            '{15'h025A,  1, 8'hA5, 0, 8'h00, 1, 8'd0},
            '{15'h0233,  3, 8'hA5, 0, 8'h00, 1, 8'd0},
            '{15'h1233,  6, 8'hA5, 0, 8'h00, 1, 8'd0},
            '{15'h1233,  1, 8'hA5, 1, 8'h5A, 1, 8'd1},
            '{15'h0233,  1, 8'hA5, 1, 8'h5A, 1, 8'd1},
            '{15'h0233,  1, 8'hA5, 0, 8'h00, 1, 8'd1},
            '{15'h1233,  7, 8'hA5, 1, 8'h5A, 1, 8'd2},
            '{15'h2233,  1, 8'hA5, 1, 8'h5A, 1, 8'd2},
            '{15'h2233,  1, 8'hA5, 0, 8'h00, 1, 8'd2},
            '{15'h2233,  9, 8'hA5, 0, 8'h00, 1, 8'd2},
            '{15'h2233,  1, 8'hFF, 0, 8'h00, 0, 8'd2},
            '{15'h2233,  4, 8'hFF, 0, 8'h00, 0, 8'd2},
            '{15'h025A,  2, 8'hFF, 0, 8'h00, 1, 8'd2},
            '{15'h025A,  5, 8'hFF, 0, 8'h00, 1, 8'd2},
            '{15'h005A,  2, 8'hFF, 0, 8'h00, 0, 8'd2},
            '{15'h045A, 14, 8'hFF, 0, 8'h00, 0, 8'd2}
        };
        SIM_RST = 1;
        SSRH    = '0;
        repeat (3) @(negedge SIM_CLK);
        chk_main("reset", 8'hFF, 0, 8'h00, 0, 8'd0);
        SIM_RST = 0;
        mon_en  = 1;
        for (int i = 0; i < 17; i++) begin
            SSRH = tbl[i].ssrh;
            repeat (tbl[i].cyc) @(negedge SIM_CLK);
            chk_main($sformatf("row%0d", i), tbl[i].fb, tbl[i].valid, tbl[i].chan, tbl[i].busy, tbl[i].cnt);
        end
        chk("wrong_stage_busy", 8'(busy[2]), 8'd0);
        chk("wrong_stage_fb",   fb[2],       8'hFF);
        SIM_RST = 1;
        @(negedge SIM_CLK);
        SIM_RST = 0;
        SSRH    = 15'h025A;
        repeat (15) @(negedge SIM_CLK);
        chk("wrap_latched_fb", fb[0], 8'hA5);
        for (int i = 0; i < 257; i++) begin
            SSRH = 15'h125A;
            repeat (8) @(negedge SIM_CLK);
            if (i == 254) chk("wrap_count_255", cnt[0], 8'd255);
            if (i == 255) chk("wrap_count_0", cnt[0], 8'd0);
            SSRH = 15'h025A;
            repeat (3) @(negedge SIM_CLK);
        end
        chk("wrap_count_1", cnt[0], 8'd1);
        SSRH = 15'h125A;
        repeat (3) @(negedge SIM_CLK);
        chk("rw_busy",  8'(busy[0]),  8'd1);
        chk("rw_valid", 8'(valid[0]), 8'd0);
        SIM_RST = 1;
        @(negedge SIM_CLK);
        chk_main("simrst", 8'hFF, 0, 8'h00, 0, 8'd0);
        SIM_RST = 0;
        SSRH    = '0;
        repeat (2) @(negedge SIM_CLK);
        for (int s = 0; s < 300; s++) begin
            logic [14:0] v;
            v       = 15'($urandom);
            v[8]    = $urandom_range(0, 3) != 0;
            v[9]    = $urandom_range(0, 3) != 0;
            v[12]   = $urandom_range(0, 1) != 0;
            v[13]   = $urandom_range(0, 9) == 0;
            SSRH    = v;
            repeat ($urandom_range(1, 14)) @(negedge SIM_CLK);
        end
        repeat (5) @(negedge SIM_CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
